// File: rtl/commit_trace_writer_pkg.sv
// Shared types for the commit trace path: writeback debug bus, trace record,
// and the default end-of-trace PC.
package commit_trace_writer_pkg;

    localparam logic [31:0] TRACE_END_PC = 32'hbfc00100;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  wstrb;
        logic [4:0]  dest;
        logic [31:0] wdata;
    } debug_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] wdata;
    } trace_rec_t;

    // Bytes not covered by the strobe read as zero in the record.
    function automatic trace_rec_t make_rec(debug_bus_t bus);
        trace_rec_t r;
        r.pc   = bus.pc;
        r.dest = bus.dest;
        for (int k = 0; k < 4; k++) begin
            r.wdata[k*8 +: 8] = bus.wstrb[k] ? bus.wdata[k*8 +: 8] : 8'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/commit_trace_writer_if.sv
// Valid/ready record stream from the trace FIFO head toward the dumper.
interface commit_trace_writer_if;
    logic                               rec_valid;
    logic                               rec_ready;
    commit_trace_writer_pkg::trace_rec_t rec;

    modport master (output rec_valid, output rec, input rec_ready);
    modport slave  (input rec_valid, input rec, output rec_ready);
endinterface

// File: rtl/commit_trace_writer_dual_push_fifo.sv
// FIFO with two ordered write ports (port 0 older) and one read port;
// full/empty derive from the occupancy counter, not pointer equality.
module dual_push_fifo
    import commit_trace_writer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr0_en,
    input  trace_rec_t               wr0_data,
    input  logic                     wr1_en,
    input  trace_rec_t               wr1_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output trace_rec_t               rd_data,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE = 1;

    trace_rec_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       occ_reg;
    logic [AW-1:0]     wr1_addr;
    logic [AW:0]       n_wr;
    logic              pop;

    assign pop      = rd_en && (occ_reg != '0);
    assign wr1_addr = wr0_en ? wr_ptr_reg + ONE : wr_ptr_reg;
    assign n_wr     = {{AW{1'b0}}, wr0_en} + {{AW{1'b0}}, wr1_en};

    // Both ports may target distinct entries in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr1_en && wr1_addr == AW'(i)) begin
                mem[i] <= wr1_data;
            end else if (wr0_en && wr_ptr_reg == AW'(i)) begin
                mem[i] <= wr0_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + n_wr[AW-1:0];
            rd_ptr_reg <= pop ? rd_ptr_reg + ONE : rd_ptr_reg;
            occ_reg    <= occ_reg + n_wr - {{AW{1'b0}}, pop};
        end
    end

    assign rd_valid  = (occ_reg != '0);
    assign rd_data   = rd_valid ? mem[rd_ptr_reg] : '0;
    assign occupancy = occ_reg;

endmodule

// File: rtl/commit_trace_writer.sv
// Turns dual-issue writeback debug buses into an in-order commit record stream,
// with sticky overflow and end-of-trace detection.
module commit_trace_writer
    import commit_trace_writer_pkg::*;
#(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] END_PC = TRACE_END_PC
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  debug_bus_t               debug_bus1,
    input  debug_bus_t               debug_bus2,
    input  logic                     trace_en,
    commit_trace_writer_if.master    stream,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              rec_count,
    output logic                     overflow,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic        overflow_reg;
    logic        done_reg;
    logic [31:0] rec_count_reg;
    logic [AW:0] free;
    logic        q1, q2, push1, push2, drop, end_hit;

    assign q1 = debug_bus1.valid && (debug_bus1.wstrb != 4'h0) && (debug_bus1.dest != 5'd0)
                && trace_en && !done_reg && !overflow_reg;
    assign q2 = debug_bus2.valid && (debug_bus2.wstrb != 4'h0) && (debug_bus2.dest != 5'd0)
                && trace_en && !done_reg && !overflow_reg;

    // Space is judged before any same-cycle pop; slot 1 claims space first.
    assign free    = DEPTH_C - occupancy;
    assign push1   = q1 && (free != '0);
    assign push2   = q2 && (push1 ? (free[AW:1] != '0) : (free != '0));
    assign drop    = (q1 && !push1) || (q2 && !push2);
    assign end_hit = (debug_bus1.valid && debug_bus1.pc == END_PC)
                  || (debug_bus2.valid && debug_bus2.pc == END_PC);

    dual_push_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .wr0_en    (push1),
        .wr0_data  (make_rec(debug_bus1)),
        .wr1_en    (push2),
        .wr1_data  (make_rec(debug_bus2)),
        .rd_en     (stream.rec_ready),
        .rd_valid  (stream.rec_valid),
        .rd_data   (stream.rec),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
            rec_count_reg <= '0;
        end else begin
            overflow_reg  <= overflow_reg || drop;
            done_reg      <= done_reg || end_hit;
            rec_count_reg <= rec_count_reg + 32'(push1) + 32'(push2);
        end
    end

    assign overflow  = overflow_reg;
    assign done      = done_reg;
    assign rec_count = rec_count_reg;

endmodule

// File: tb/tb_commit_trace_writer.sv
// Randomized and directed checks of commit_trace_writer against a queue-based model.
module tb_commit_trace_writer;
    import commit_trace_writer_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn;
    debug_bus_t  b1, b2;
    logic        trace_en;
    logic [4:0]  occupancy;
    logic [31:0] rec_count;
    logic        overflow, done;

    commit_trace_writer_if stream();

    always #5 clk = ~clk;

    commit_trace_writer #(.DEPTH(DEPTH), .END_PC(TRACE_END_PC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .debug_bus1 (b1),
        .debug_bus2 (b2),
        .trace_en   (trace_en),
        .stream     (stream),
        .occupancy  (occupancy),
        .rec_count  (rec_count),
        .overflow   (overflow),
        .done       (done)
    );

    // Model state: contents of the FIFO as a queue plus the sticky flags.
    trace_rec_t  mq[$];
    int unsigned m_count;
    bit          m_ovf, m_done;
    int          n_cmp = 0, n_err = 0, n_pop = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rec_valid", stream.rec_valid, mq.size() != 0);
        if (mq.size() != 0) chk("rec", stream.rec, mq[0]);
        else                chk("rec_idle", stream.rec, '0);
        chk("occupancy", occupancy, mq.size());
        chk("rec_count", rec_count, m_count);
        chk("overflow", overflow, m_ovf);
        chk("done", done, m_done);
    endtask

    function automatic debug_bus_t mkbus(bit v, logic [31:0] pc, logic [3:0] s,
                                         logic [4:0] d, logic [31:0] w);
        debug_bus_t b;
        b.valid = v; b.pc = pc; b.wstrb = s; b.dest = d; b.wdata = w;
        return b;
    endfunction

    function automatic trace_rec_t expect_rec(debug_bus_t b);
        trace_rec_t r;
        r.pc    = b.pc;
        r.dest  = b.dest;
        r.wdata = b.wdata & {{8{b.wstrb[3]}}, {8{b.wstrb[2]}}, {8{b.wstrb[1]}}, {8{b.wstrb[0]}}};
        return r;
    endfunction

    // One clock of behaviour: accept in slot order while room remains, pop the head.
    task automatic model_step();
        debug_bus_t bb[2];
        trace_rec_t acc[$];
        trace_rec_t r;
        int         n, room;
        bit         ovf_new, done_new;
        bb[0] = b1; bb[1] = b2;
        n = mq.size(); room = DEPTH - n;
        ovf_new = m_ovf; done_new = m_done;
        for (int s = 0; s < 2; s++) begin
            if (bb[s].valid && bb[s].wstrb != 0 && bb[s].dest != 0 && trace_en && !m_done && !m_ovf) begin
                if (acc.size() < room) acc.push_back(expect_rec(bb[s]));
                else ovf_new = 1'b1;
            end
            if (bb[s].valid && bb[s].pc == TRACE_END_PC) done_new = 1'b1;
        end
        if (stream.rec_ready && n > 0) begin
            r = mq.pop_front();
            n_pop++;
            $display("pop %0d: pc=%h dest=%0d wdata=%h", n_pop, r.pc, r.dest, r.wdata);
        end
        foreach (acc[i]) mq.push_back(acc[i]);
        m_count += acc.size();
        m_ovf  = ovf_new;
        m_done = done_new;
    endtask

    task automatic cycle(debug_bus_t x1, debug_bus_t x2, bit en, bit rdy);
        b1 = x1; b2 = x2; trace_en = en; stream.rec_ready = rdy;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic model_clear();
        mq.delete(); m_count = 0; m_ovf = 0; m_done = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        b1 = '0; b2 = '0; trace_en = 1'b0; stream.rec_ready = 1'b0;
        model_clear();
        @(negedge clk);
        check_all();
        resetn = 1'b1;
    endtask

    function automatic debug_bus_t rnd_bus(int pv);
        debug_bus_t b;
        b.valid = ($urandom_range(0, 99) < pv);
        b.pc    = {$urandom(), 2'b00} >> 2 << 2;
        if ($urandom_range(0, 299) == 0) b.pc = TRACE_END_PC;
        else if (b.pc == TRACE_END_PC) b.pc = 32'h0;
        b.wstrb = 4'($urandom());
        b.dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom());
        b.wdata = $urandom();
        return b;
    endfunction

    debug_bus_t none_b, s1, s2, qa, qb;
    trace_rec_t lit;
    int         pvs[4] = '{30, 50, 80, 20};
    int         prs[4] = '{90, 100, 50, 70};

    initial begin
        none_b = '0;
        resetn = 1'b0;
        b1 = '0; b2 = '0; trace_en = 1'b0; stream.rec_ready = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("reset_rec_valid", stream.rec_valid, 1'b0);
        chk("reset_occupancy", occupancy, 5'd0);
        chk("reset_rec_count", rec_count, 32'd0);
        chk("reset_flags", {overflow, done}, 2'b00);
        check_all();
        resetn = 1'b1;

        // Ordered dual push with strobe masking on slot 2.
        s1 = mkbus(1, 32'hbfc00000, 4'hf, 5'd2, 32'h12345678);
        s2 = mkbus(1, 32'hbfc00004, 4'h3, 5'd3, 32'haabbccdd);
        cycle(s1, s2, 1, 1);
        lit = '{pc: 32'hbfc00000, dest: 5'd2, wdata: 32'h12345678};
        chk("t1_head1", stream.rec, lit);
        chk("t1_count", rec_count, 32'd2);
        cycle(none_b, none_b, 1, 1);
        lit = '{pc: 32'hbfc00004, dest: 5'd3, wdata: 32'h0000ccdd};
        chk("t1_head2", stream.rec, lit);
        cycle(none_b, none_b, 1, 1);
        chk("t1_empty", stream.rec_valid, 1'b0);

        // Non-qualifying commits: dest 0, wstrb 0, then tracing disabled.
        cycle(mkbus(1, 32'h100, 4'hf, 5'd0, 32'h1), mkbus(1, 32'h104, 4'h0, 5'd5, 32'h2), 1, 1);
        cycle(mkbus(1, 32'h108, 4'hf, 5'd1, 32'h3), mkbus(1, 32'h10c, 4'hf, 5'd6, 32'h4), 0, 1);
        chk("t2_count", rec_count, 32'd2);
        chk("t2_valid", stream.rec_valid, 1'b0);

        // Fill to DEPTH with ready low, overflow on the next cycle, then drain.
        for (int i = 0; i < 8; i++) begin
            qa = mkbus(1, 32'h1000 + i*8, 4'hf, 5'(i + 1), $urandom());
            qb = mkbus(1, 32'h1004 + i*8, 4'hc, 5'(i + 9), $urandom());
            cycle(qa, qb, 1, 0);
        end
        chk("t3_full_occ", occupancy, 5'd16);
        chk("t3_no_ovf_yet", overflow, 1'b0);
        cycle(qa, qb, 1, 0);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_occ_after_ovf", occupancy, 5'd16);
        for (int i = 0; i < 20; i++) cycle(qa, qb, 1, 1);
        chk("t3_drained", occupancy, 5'd0);
        chk("t3_count", rec_count, 32'd18);

        // Occupancy 15 with two qualifying slots and a simultaneous pop.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(qa, qb, 1, 0);
        cycle(qa, none_b, 1, 0);
        chk("t4_occ15", occupancy, 5'd15);
        cycle(qa, qb, 1, 1);
        chk("t4_occ_end", occupancy, 5'd15);
        chk("t4_ovf", overflow, 1'b1);
        chk("t4_count", rec_count, 32'd16);

        // END_PC on slot 2 is still recorded, then nothing further is pushed.
        do_reset();
        cycle(none_b, mkbus(1, TRACE_END_PC, 4'hf, 5'd4, 32'hcafef00d), 1, 0);
        chk("t5_done", done, 1'b1);
        chk("t5_count", rec_count, 32'd1);
        cycle(qa, qb, 1, 0);
        chk("t5_ignored", rec_count, 32'd1);
        chk("t5_occ", occupancy, 5'd1);

        // Asynchronous reset while draining with five entries held.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(qa, qb, 1, 0);
        cycle(none_b, none_b, 1, 1);
        chk("t6_occ5", occupancy, 5'd5);
        #2 resetn = 1'b0;
        #1;
        chk("t6_async_valid", stream.rec_valid, 1'b0);
        chk("t6_async_rec", stream.rec, '0);
        chk("t6_async_occ", occupancy, 5'd0);
        chk("t6_async_count", rec_count, 32'd0);
        chk("t6_async_flags", {overflow, done}, 2'b00);
        model_clear();
        b1 = '0; b2 = '0; stream.rec_ready = 1'b0;
        @(negedge clk);
        check_all();
        resetn = 1'b1;

        // Randomized episodes with varying commit density and back-pressure.
        for (int e = 0; e < 4; e++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                cycle(rnd_bus(pvs[e]), rnd_bus(pvs[e]), ($urandom_range(0, 19) != 0),
                      ($urandom_range(0, 99) < prs[e]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
